// File: rtl/mem_access_ctrl_pkg.sv
// Shared CPU-wide definitions for the memory stage and data bus.
//   - strobe_type encodings coming from the MEM stage (ST_WORD/ST_HALF/ST_BYTE)
//   - data-bus transfer size enum and request/response bundles
//   - controller FSM state enum
//   - small decode helpers shared by the controller and the load-extension unit
package mem_access_ctrl_pkg;

  // strobe_type from the pipeline: 00 word, 01 half, 1x byte
  localparam logic [1:0] ST_WORD = 2'b00;
  localparam logic [1:0] ST_HALF = 2'b01;
  localparam logic [1:0] ST_BYTE = 2'b10;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } dbus_size_e;

  typedef struct packed {
    logic        valid;
    logic        write;
    dbus_size_e  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } mac_state_e;

  // Both 10 and 11 mean byte, so only the upper bit matters.
  function automatic logic is_byte(input logic [1:0] st);
    return (st & ST_BYTE) == ST_BYTE;
  endfunction

  function automatic dbus_size_e size_of(input logic [1:0] st);
    if (is_byte(st))    return SZ_BYTE;
    if (st == ST_HALF)  return SZ_HALF;
    return SZ_WORD;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] st, input logic [1:0] tail);
    if (is_byte(st))   return 1'b0;
    if (st == ST_HALF) return tail[0];
    return tail != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_extension.sv
// Load-extension unit: picks the addressed byte/half out of a raw 32-bit
// bus word and sign- or zero-extends it to 32 bits. Words pass through.
// Ports:
//   strobe_type_i  access width (ST_WORD / ST_HALF / byte)
//   extend_i       1 = sign-extend, 0 = zero-extend
//   addr_tail_i    low two address bits selecting the lane
//   raw_i          raw word returned by the bus
//   ext_o          extended, right-aligned result
module mem_extension
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  strobe_type_i,
  input  logic        extend_i,
  input  logic [1:0]  addr_tail_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = addr_tail_i[1] ? raw_i[31:16] : raw_i[15:0];
    case (addr_tail_i)
      2'd0:    byte_sel = raw_i[7:0];
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      default: byte_sel = raw_i[31:24];
    endcase

    ext_o = raw_i;
    if (is_byte(strobe_type_i)) begin
      ext_o = {{24{extend_i & byte_sel[7]}}, byte_sel};
    end else if (strobe_type_i == ST_HALF) begin
      ext_o = {{16{extend_i & half_sel[15]}}, half_sel};
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller. Runs one data-bus transaction per load/store,
// stalling the pipeline until it completes. Stores get byte strobes and
// lane-replicated data; loads are extended through mem_extension.
// Ports:
//   clk, reset                  clock, async active-high reset
//   mem_valid/write/strobe_type/mem_extend/mem_addr/mem_wdata/flush
//                               operation presented by the MEM stage
//   stall, done, rdata, misalign
//                               pipeline-facing status and load result
//   dreq_*                      data-bus request (held stable while in REQ)
//   dresp_*                     data-bus handshake and read data
//
// state | meaning
// IDLE  | no transaction; accepts an aligned op from MEM
// REQ   | request on the bus, waiting for addr_ok
// WAIT  | request accepted, waiting for data_ok
// DONE  | completion cycle; done pulses unless the op was flushed
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32   // lane math assumes 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_write,
  input  logic [1:0]        strobe_type,
  input  logic              mem_extend,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign,
  output logic              dreq_valid,
  output logic              dreq_write,
  output logic [1:0]        dreq_size,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [3:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data
);

  mac_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        type_q;
  logic              ext_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] resp_q;
  logic              dropped_q, dropped_d;
  logic              misalign_q, misalign_d;
  logic              latch_req;
  logic              capture;

  dbus_req_t         req;
  dbus_resp_t        resp;
  logic [31:0]       ext_data;

  always_comb begin
    resp.addr_ok = dresp_addr_ok;
    resp.data_ok = dresp_data_ok;
    resp.data    = dresp_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      type_q     <= '0;
      ext_q      <= 1'b0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      resp_q     <= '0;
      dropped_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dropped_q  <= dropped_d;
      misalign_q <= misalign_d;
      if (latch_req) begin
        addr_q  <= mem_addr;
        type_q  <= strobe_type;
        ext_q   <= mem_extend;
        write_q <= mem_write;
        wdata_q <= mem_wdata;
      end
      if (capture) begin
        resp_q <= resp.data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    dropped_d  = dropped_q;
    misalign_d = 1'b0;
    latch_req  = 1'b0;
    capture    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // While misalign_q is high the MEM stage still shows the faulting
        // op; it moves on this cycle, so it must not be decoded twice.
        if (mem_valid && !flush && !misalign_q) begin
          if (is_misaligned(strobe_type, mem_addr[1:0])) begin
            misalign_d = 1'b1;
          end else begin
            latch_req = 1'b1;
            dropped_d = 1'b0;
            state_d   = S_REQ;
          end
        end
      end
      S_REQ: begin
        // A started transaction cannot be withdrawn; only its result is dropped.
        if (flush) dropped_d = 1'b1;
        if (resp.addr_ok) begin
          if (resp.data_ok) begin
            capture = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) dropped_d = 1'b1;
        if (resp.data_ok) begin
          capture = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        dropped_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_comb begin
    req = '0;
    if (state_q == S_REQ) begin
      req.valid = 1'b1;
      req.write = write_q;
      req.size  = size_of(type_q);
      req.addr  = addr_q;
      if (write_q) begin
        if (is_byte(type_q)) begin
          req.strobe = 4'b0001 << addr_q[1:0];
          req.data   = {4{wdata_q[7:0]}};
        end else if (type_q == ST_HALF) begin
          req.strobe = 4'b0011 << {addr_q[1], 1'b0};
          req.data   = {2{wdata_q[15:0]}};
        end else begin
          req.strobe = 4'b1111;
          req.data   = wdata_q;
        end
      end
    end
  end

  mem_extension u_ext (
    .strobe_type_i (type_q),
    .extend_i      (ext_q),
    .addr_tail_i   (addr_q[1:0]),
    .raw_i         (resp_q),
    .ext_o         (ext_data)
  );

  always_comb begin
    dreq_valid  = req.valid;
    dreq_write  = req.write;
    dreq_size   = req.size;
    dreq_addr   = req.addr;
    dreq_strobe = req.strobe;
    dreq_data   = req.data;

    done     = (state_q == S_DONE) && !dropped_q;
    rdata    = (done && !write_q) ? ext_data : '0;
    misalign = misalign_q;
    // Reset gates stall so every output reads 0 while reset is held.
    stall    = !reset && ((state_q == S_REQ) || (state_q == S_WAIT) ||
                          (mem_valid && !done && !misalign_q));
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        mem_valid, mem_write, mem_extend, flush;
  logic [1:0]  strobe_type;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall, done, misalign;
  logic [31:0] rdata;
  logic        dreq_valid, dreq_write;
  logic [1:0]  dreq_size;
  logic [31:0] dreq_addr, dreq_data;
  logic [3:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_write(mem_write), .strobe_type(strobe_type),
    .mem_extend(mem_extend), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .flush(flush), .stall(stall), .done(done), .rdata(rdata), .misalign(misalign),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_size(dreq_size),
    .dreq_addr(dreq_addr), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  st;
    logic        ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] resp;
    int          aok;       // REQ cycles before addr_ok
    int          dok;       // cycles from addr_ok to data_ok (0 = same cycle)
    logic        exp_mis;
    logic [3:0]  exp_strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_size;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs[NV];

  task automatic chk(input logic [31:0] act, input logic [31:0] exp, input string nm, input int idx);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: actual %h required %h", nm, idx, act, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_vec(input vec_t v, input int idx);
    int cyc;
    int acc_cyc;
    bit acc;
    bit fin;
    mem_valid = 1'b1; mem_write = v.wr; strobe_type = v.st; mem_extend = v.ext;
    mem_addr = v.addr; mem_wdata = v.wdata;
    @(negedge clk);
    chk(stall, 1, "stall_idle", idx);
    chk(dreq_valid, 0, "dreq_valid_idle", idx);
    @(posedge clk); #1;
    if (v.exp_mis) begin
      @(negedge clk);
      chk(misalign, 1, "misalign_pulse", idx);
      chk(stall, 0, "stall_misalign", idx);
      chk(dreq_valid, 0, "dreq_valid_misalign", idx);
      chk(done, 0, "done_misalign", idx);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      @(negedge clk);
      chk(misalign, 0, "misalign_one_cycle", idx);
      chk(dreq_valid, 0, "dreq_valid_after_mis", idx);
      chk(done, 0, "done_after_mis", idx);
      @(posedge clk); #1;
      return;
    end
    acc = 0; fin = 0; cyc = 0; acc_cyc = 0;
    while (!fin && cyc < 20) begin
      if (!acc) begin
        dresp_addr_ok = (cyc == v.aok);
        dresp_data_ok = dresp_addr_ok && (v.dok == 0);
      end else begin
        dresp_addr_ok = 1'b0;
        dresp_data_ok = ((cyc - acc_cyc) == v.dok);
      end
      dresp_data = dresp_data_ok ? v.resp : 32'h5A5A_5A5A;
      @(negedge clk);
      chk(stall, 1, "stall_busy", idx);
      chk(done, 0, "done_early", idx);
      if (!acc) begin
        chk(dreq_valid, 1, "dreq_valid", idx);
        chk(dreq_write, v.wr, "dreq_write", idx);
        chk(dreq_size, v.exp_size, "dreq_size", idx);
        chk(dreq_addr, v.addr, "dreq_addr", idx);
        chk(dreq_strobe, v.exp_strb, "dreq_strobe", idx);
        chk(dreq_data, v.exp_data, "dreq_data", idx);
      end else begin
        chk(dreq_valid, 0, "dreq_valid_wait", idx);
      end
      if (dresp_addr_ok) begin acc = 1; acc_cyc = cyc; end
      if (dresp_data_ok) fin = 1;
      @(posedge clk); #1;
      dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
      cyc++;
    end
    if (!fin) begin
      n_tests++; n_fail++;
      $display("FAIL bus_timeout [%0d]: actual no handshake required handshake", idx);
    end
    @(negedge clk);
    chk(done, 1, "done_pulse", idx);
    chk(rdata, v.exp_rdata, "rdata", idx);
    chk(stall, 0, "stall_done", idx);
    chk(dreq_valid, 0, "dreq_valid_done", idx);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    @(negedge clk);
    chk(done, 0, "done_one_cycle", idx);
    chk(stall, 0, "stall_after", idx);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //              wr  st     ext  addr          wdata         resp          aok dok mis strb     data          size   rdata
    vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'h0,        32'hDEAD_BEEF, 0, 0, 1'b0, 4'b0000, 32'h0,        2'd2, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'h0,        32'h8011_2233, 0, 2, 1'b0, 4'b0000, 32'h0,        2'd0, 32'hFFFF_FF80};
    vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h0000_1003, 32'h0,        32'h8011_2233, 0, 2, 1'b0, 4'b0000, 32'h0,        2'd0, 32'h0000_0080};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h1234_5678, 3, 0, 1'b0, 4'b1100, 32'hABCD_ABCD, 2'd1, 32'h0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h0000_1002, 32'h0,        32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,        2'd2, 32'h0};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h0000_3002, 32'h0,        32'h8001_7FFF, 1, 1, 1'b0, 4'b0000, 32'h0,        2'd1, 32'hFFFF_8001};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h0000_3000, 32'h0,        32'h8001_F234, 0, 0, 1'b0, 4'b0000, 32'h0,        2'd1, 32'h0000_F234};
    vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h0000_4001, 32'h1234_56C3, 32'h0,         0, 1, 1'b0, 4'b0010, 32'hC3C3_C3C3, 2'd0, 32'h0};
    vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h0000_5004, 32'hCAFE_F00D, 32'h0,         2, 0, 1'b0, 4'b1111, 32'hCAFE_F00D, 2'd2, 32'h0};
    vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h0000_3001, 32'h0,        32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,        2'd1, 32'h0};
    vecs[10] = '{1'b0, 2'b10, 1'b1, 32'h0000_6000, 32'h0,        32'h0000_007F, 0, 0, 1'b0, 4'b0000, 32'h0,        2'd0, 32'h0000_007F};
    vecs[11] = '{1'b0, 2'b11, 1'b1, 32'h0000_6002, 32'h0,        32'h00A5_0000, 0, 1, 1'b0, 4'b0000, 32'h0,        2'd0, 32'hFFFF_FFA5};
    vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h0000_7001, 32'h0,        32'h0,         0, 0, 1'b1, 4'b0000, 32'h0,        2'd2, 32'h0};

    reset = 1'b1; mem_valid = 1'b0; mem_write = 1'b0; strobe_type = 2'b00; mem_extend = 1'b0;
    mem_addr = 32'h0; mem_wdata = 32'h0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 32'h0;

    @(negedge clk);
    chk(stall, 0, "rst_stall", 0);
    chk(done, 0, "rst_done", 0);
    chk(misalign, 0, "rst_misalign", 0);
    chk(rdata, 0, "rst_rdata", 0);
    chk(dreq_valid, 0, "rst_dreq_valid", 0);
    chk(dreq_strobe, 0, "rst_dreq_strobe", 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // flush alongside mem_valid in IDLE: ignored, no bus request
    mem_valid = 1'b1; mem_write = 1'b0; strobe_type = 2'b00; mem_addr = 32'h0000_1000; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; mem_valid = 1'b0;
    @(negedge clk);
    chk(dreq_valid, 0, "flush_idle_no_req", 100);
    chk(stall, 0, "flush_idle_stall", 100);
    @(posedge clk); #1;

    // flush in WAIT on a half load: handshake completes, result dropped
    mem_valid = 1'b1; mem_write = 1'b0; strobe_type = 2'b01; mem_extend = 1'b1; mem_addr = 32'h0000_3002;
    @(posedge clk); #1;
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    chk(dreq_valid, 1, "flush_req_valid", 101);
    @(posedge clk); #1;
    dresp_addr_ok = 1'b0; flush = 1'b1; mem_valid = 1'b0;
    @(negedge clk);
    chk(stall, 1, "flush_wait_stall", 101);
    chk(dreq_valid, 0, "flush_wait_novalid", 101);
    @(posedge clk); #1;
    flush = 1'b0; dresp_data_ok = 1'b1; dresp_data = 32'h8001_7FFF;
    @(negedge clk);
    chk(stall, 1, "flush_dataok_stall", 101);
    chk(done, 0, "flush_dataok_done", 101);
    @(posedge clk); #1;
    dresp_data_ok = 1'b0;
    @(negedge clk);
    chk(done, 0, "flush_no_done", 101);
    chk(rdata, 0, "flush_no_rdata", 101);
    chk(stall, 0, "flush_done_stall", 101);
    @(posedge clk); #1;
    @(negedge clk);
    chk(dreq_valid, 0, "flush_back_idle", 101);
    chk(done, 0, "flush_idle_done", 101);
    @(posedge clk); #1;
    run_vec(vecs[0], 102);

    // async reset while in REQ
    mem_valid = 1'b1; mem_write = 1'b0; strobe_type = 2'b00; mem_addr = 32'h0000_1000;
    @(posedge clk); #1;
    @(negedge clk);
    chk(dreq_valid, 1, "rstreq_valid", 103);
    #2 reset = 1'b1;
    #1;
    chk(dreq_valid, 0, "rstreq_async_valid", 103);
    chk(dreq_addr, 0, "rstreq_async_addr", 103);
    chk(stall, 0, "rstreq_async_stall", 103);
    chk(done, 0, "rstreq_async_done", 103);
    chk(misalign, 0, "rstreq_async_mis", 103);
    mem_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk(dreq_valid, 0, "rstreq_idle_valid", 103);
    chk(stall, 0, "rstreq_idle_stall", 103);
    @(posedge clk); #1;
    run_vec(vecs[1], 104);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
